// File: rtl/riscy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscy_pkg: opcodes, flag indices, phase codes and FSM types for RISCY |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package riscy_pkg;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_B     = 4'd8;
  localparam logic [3:0] OP_BZ    = 4'd9;
  localparam logic [3:0] OP_BN    = 4'd10;
  localparam logic [3:0] OP_BV    = 4'd11;
  localparam logic [3:0] OP_BC    = 4'd12;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam logic [1:0] PHASE_FETCH  = 2'd0;
  localparam logic [1:0] PHASE_DECODE = 2'd1;
  localparam logic [1:0] PHASE_EXEC   = 2'd2;
  localparam logic [1:0] PHASE_UPD    = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPD    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_STORE = 2'd1,
    CLS_ALU   = 2'd2,
    CLS_BR    = 2'd3
  } cls_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_BC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscy_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscy_wait_timer: counts consecutive memory wait cycles, flags timeout|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module riscy_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic timeout
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  // The current wait cycle is the WAIT_MAX-th one.
  assign timeout = run && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/riscy_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscy_seq_ctrl: FETCH/DECODE/EXEC/UPD sequencer with waits and traps  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module riscy_seq_ctrl
  import riscy_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       OPCODE,
  input  logic [3:0]       FLAGS,
  input  logic             MEM_RDY,
  input  logic             HALT_REQ,
  output logic [1:0]       PHASE,
  output logic             IR_EN,
  output logic             A_EN,
  output logic             RDR_EN,
  output logic             ALU_EN,
  output logic             ALU_OE,
  output logic             RAM_OE,
  output logic             RAM_WE,
  output logic             PC_EN,
  output logic             PC_LOAD,
  output logic             RAM_CS_N,
  output logic             HALTED,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_t           state, state_nxt;
  cls_t             cls, dec_cls;
  logic             take, dec_take;
  logic             err, err_set;
  logic [CNT_W-1:0] cnt;
  logic             in_access, run, clr, timeout;

  assign in_access = (state == ST_FETCH) ||
                     ((state == ST_EXEC) && ((cls == CLS_LOAD) || (cls == CLS_STORE)));
  assign run = in_access && !MEM_RDY;
  assign clr = MEM_RDY || (state_nxt != state);

  riscy_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk     (CLK),
    .rst     (RST),
    .clr     (clr),
    .run     (run),
    .timeout (timeout)
  );

  always_comb begin
    dec_cls  = CLS_BR;
    dec_take = 1'b0;
    if (OPCODE == OP_LOAD)                           dec_cls = CLS_LOAD;
    else if (OPCODE == OP_STORE)                     dec_cls = CLS_STORE;
    else if (OPCODE >= OP_ADD && OPCODE <= OP_NOT)   dec_cls = CLS_ALU;
    case (OPCODE)
      OP_B:    dec_take = 1'b1;
      OP_BZ:   dec_take = FLAGS[FLAG_Z];
      OP_BN:   dec_take = FLAGS[FLAG_N];
      OP_BV:   dec_take = FLAGS[FLAG_V];
      OP_BC:   dec_take = FLAGS[FLAG_C];
      default: dec_take = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (MEM_RDY)      state_nxt = ST_DECODE;
        else if (timeout) begin state_nxt = ST_HALT; err_set = 1'b1; end
      end
      ST_DECODE: begin
        if (is_illegal(OPCODE)) begin state_nxt = ST_HALT; err_set = 1'b1; end
        else                    state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls == CLS_LOAD || cls == CLS_STORE) begin
          if (MEM_RDY)      state_nxt = ST_UPD;
          else if (timeout) begin state_nxt = ST_HALT; err_set = 1'b1; end
        end else begin
          state_nxt = ST_UPD;
        end
      end
      ST_UPD:  state_nxt = HALT_REQ ? ST_HALT : ST_FETCH;
      ST_HALT: if (!HALT_REQ && !err) state_nxt = ST_FETCH;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
      cls   <= CLS_ALU;
      take  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        cls  <= dec_cls;
        take <= dec_take;
      end
      if (err_set)          err <= 1'b1;
      if (state == ST_UPD)  cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    IR_EN = 1'b0; A_EN = 1'b0; RDR_EN = 1'b0; ALU_EN = 1'b0; ALU_OE = 1'b0;
    RAM_OE = 1'b0; RAM_WE = 1'b0; PC_EN = 1'b0; PC_LOAD = 1'b0; RAM_CS_N = 1'b1;
    PHASE = PHASE_FETCH;
    case (state)
      ST_FETCH: begin
        RAM_CS_N = 1'b0;
        RAM_OE   = 1'b1;
        IR_EN    = MEM_RDY;
      end
      ST_DECODE: PHASE = PHASE_DECODE;
      ST_EXEC: begin
        PHASE = PHASE_EXEC;
        case (cls)
          CLS_ALU: begin ALU_EN = 1'b1; ALU_OE = 1'b1; end
          CLS_LOAD: begin
            RAM_CS_N = 1'b0;
            RAM_OE   = 1'b1;
            RDR_EN   = MEM_RDY;
            A_EN     = MEM_RDY;
          end
          CLS_STORE: begin
            ALU_OE   = 1'b1;
            RAM_CS_N = 1'b0;
            RAM_WE   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_UPD: begin
        PHASE   = PHASE_UPD;
        PC_EN   = 1'b1;
        PC_LOAD = take;
      end
      default: ;
    endcase
    // Reset kills every strobe immediately, before the state register follows.
    if (RST) begin
      IR_EN = 1'b0; A_EN = 1'b0; RDR_EN = 1'b0; ALU_EN = 1'b0; ALU_OE = 1'b0;
      RAM_OE = 1'b0; RAM_WE = 1'b0; PC_EN = 1'b0; PC_LOAD = 1'b0; RAM_CS_N = 1'b1;
    end
  end

  assign HALTED    = (state == ST_HALT);
  assign ERR       = err;
  assign INSTR_CNT = cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscy_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscy_seq_ctrl: directed self-checking bench (WAIT_MAX=4, CNT_W=2) |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_riscy_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [3:0] flags = 4'd0;
  logic       mem_rdy = 1'b1;
  logic       halt_req = 1'b0;
  logic [1:0] phase;
  logic       ir_en, a_en, rdr_en, alu_en, alu_oe, ram_oe, ram_we, pc_en, pc_load;
  logic       ram_cs_n, halted, err;
  logic [1:0] instr_cnt;
  logic [9:0] strb;

  int total = 0;
  int bad   = 0;

  // Strobe codes: {IR,A,RDR,ALU_EN,ALU_OE,RAM_OE,RAM_WE,PC_EN,PC_LOAD,CS_N}
  localparam logic [9:0] S_IDLE  = 10'h001;
  localparam logic [9:0] S_FWAIT = 10'h010;
  localparam logic [9:0] S_FRDY  = 10'h210;
  localparam logic [9:0] S_ALU   = 10'h061;
  localparam logic [9:0] S_LWAIT = 10'h010;
  localparam logic [9:0] S_LRDY  = 10'h190;
  localparam logic [9:0] S_ST    = 10'h028;
  localparam logic [9:0] S_UPD   = 10'h005;
  localparam logic [9:0] S_UPDT  = 10'h007;

  always #5 clk = ~clk;

  riscy_seq_ctrl #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .FLAGS(flags), .MEM_RDY(mem_rdy),
    .HALT_REQ(halt_req), .PHASE(phase), .IR_EN(ir_en), .A_EN(a_en), .RDR_EN(rdr_en),
    .ALU_EN(alu_en), .ALU_OE(alu_oe), .RAM_OE(ram_oe), .RAM_WE(ram_we), .PC_EN(pc_en),
    .PC_LOAD(pc_load), .RAM_CS_N(ram_cs_n), .HALTED(halted), .ERR(err),
    .INSTR_CNT(instr_cnt)
  );

  assign strb = {ir_en, a_en, rdr_en, alu_en, alu_oe, ram_oe, ram_we, pc_en, pc_load, ram_cs_n};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set before the call; checks land mid-cycle, then one full clock passes.
  task automatic cyc(input string tag, input logic [1:0] ph, input logic [9:0] st);
    #1;
    chk({tag, " phase"}, 32'(phase), 32'(ph));
    chk({tag, " strobes"}, 32'(strb), 32'(st));
    @(negedge clk);
  endtask

  task automatic instr(input string tag, input logic [3:0] op, input logic [3:0] fl,
                       input int fwait, input int ewait, input logic [9:0] ex_w,
                       input logic [9:0] ex_r, input logic [9:0] upd,
                       input logic hf, input logic hu);
    opcode = op; flags = fl; halt_req = hf;
    for (int i = 0; i < fwait; i++) begin
      mem_rdy = 1'b0;
      cyc({tag, " fetch-wait"}, 2'd0, S_FWAIT);
    end
    mem_rdy = 1'b1;
    cyc({tag, " fetch"}, 2'd0, S_FRDY);
    halt_req = 1'b0;
    cyc({tag, " decode"}, 2'd1, S_IDLE);
    for (int i = 0; i < ewait; i++) begin
      mem_rdy = 1'b0;
      cyc({tag, " exec-wait"}, 2'd2, ex_w);
    end
    mem_rdy = 1'b1;
    cyc({tag, " exec"}, 2'd2, ex_r);
    halt_req = hu;
    cyc({tag, " upd"}, 2'd3, upd);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset strobes gated", 32'(strb), 32'(S_IDLE));
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD with three fetch waits: the 4th cycle is ready, so no timeout.
    instr("add", 4'h2, 4'h0, 3, 0, S_IDLE, S_ALU, S_UPD, 1'b0, 1'b0);
    chk("add err", 32'(err), 32'd0);
    chk("add cnt", 32'(instr_cnt), 32'd1);
    instr("bz-taken", 4'h9, 4'h1, 0, 0, S_IDLE, S_IDLE, S_UPDT, 1'b0, 1'b0);
    instr("bz-not", 4'h9, 4'h0, 0, 0, S_IDLE, S_IDLE, S_UPD, 1'b0, 1'b0);
    instr("b", 4'h8, 4'h0, 0, 0, S_IDLE, S_IDLE, S_UPDT, 1'b0, 1'b0);
    instr("bc-c", 4'hC, 4'h8, 0, 0, S_IDLE, S_IDLE, S_UPDT, 1'b0, 1'b0);
    chk("cnt wrap", 32'(instr_cnt), 32'd1);
    instr("load", 4'h0, 4'h0, 0, 3, S_LWAIT, S_LRDY, S_UPD, 1'b0, 1'b0);
    chk("load cnt", 32'(instr_cnt), 32'd2);
    instr("store", 4'h1, 4'h0, 0, 1, S_ST, S_ST, S_UPD, 1'b0, 1'b0);
    instr("sub-pulse", 4'h3, 4'h0, 0, 0, S_IDLE, S_ALU, S_UPD, 1'b1, 1'b0);
    chk("pulse ignored", 32'(halted), 32'd0);
    chk("five-later cnt", 32'(instr_cnt), 32'd0);
    instr("bn-halt", 4'hA, 4'h0, 0, 0, S_IDLE, S_IDLE, S_UPD, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc("halt hold", 2'd0, S_IDLE);
    end
    chk("halt halted", 32'(halted), 32'd1);
    halt_req = 1'b0;
    #1 chk("halt release same cycle", 32'(halted), 32'd1);
    @(negedge clk);

    // Resume directly into a STORE, then reset during its wait.
    opcode = 4'h1;
    chk("resume halted", 32'(halted), 32'd0);
    cyc("resume fetch", 2'd0, S_FRDY);
    cyc("st-rst decode", 2'd1, S_IDLE);
    mem_rdy = 1'b0;
    cyc("st-rst wait", 2'd2, S_ST);
    rst = 1'b1;
    #1 chk("st-rst gated", 32'(strb), 32'(S_IDLE));
    @(negedge clk);
    #1;
    chk("st-rst cs_n", 32'(ram_cs_n), 32'd1);
    chk("st-rst we", 32'(ram_we), 32'd0);
    chk("st-rst phase", 32'(phase), 32'd0);
    chk("st-rst cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_rdy = 1'b1;

    // Illegal opcode traps after DECODE.
    opcode = 4'hE;
    cyc("ill fetch", 2'd0, S_FRDY);
    cyc("ill decode", 2'd1, S_IDLE);
    chk("ill err", 32'(err), 32'd1);
    chk("ill halted", 32'(halted), 32'd1);
    chk("ill cnt", 32'(instr_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("ill hold", 2'd0, S_IDLE);
    end
    chk("ill stays halted", 32'(halted), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ill reset err", 32'(err), 32'd0);
    chk("ill reset halted", 32'(halted), 32'd0);

    // Fetch timeout with WAIT_MAX=4.
    opcode = 4'h2;
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("to err before", 32'(err), 32'd0);
      cyc("to wait", 2'd0, S_FWAIT);
    end
    mem_rdy = 1'b1;
    #1;
    chk("to err", 32'(err), 32'd1);
    chk("to halted", 32'(halted), 32'd1);
    chk("to strobes", 32'(strb), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    chk("to stays halted", 32'(halted), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("to reset err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
